// File: rtl/robotarm_pkg.sv
// Shared widths, home pose, dwell-code and scheduler-state encodings for the arm
// command path.
package robotarm_pkg;

  localparam int SERVO_W = 12;
  localparam int POSE_W  = 60;

  localparam logic [SERVO_W-1:0] HOME_LOC1 = 12'd2048;
  localparam logic [SERVO_W-1:0] HOME_LOC2 = 12'd1850;
  localparam logic [SERVO_W-1:0] HOME_LOC3 = 12'd3227;
  localparam logic [SERVO_W-1:0] HOME_LOC4 = 12'd3000;
  localparam logic [SERVO_W-1:0] HOME_LOC5 = 12'd2048;
  localparam logic [POSE_W-1:0]  HOME_POSE =
    {HOME_LOC5, HOME_LOC4, HOME_LOC3, HOME_LOC2, HOME_LOC1};

  typedef enum logic [1:0] {
    DWELL_C0 = 2'd0,
    DWELL_C1 = 2'd1,
    DWELL_C2 = 2'd2,
    DWELL_C3 = 2'd3
  } dwell_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_DWELL   = 3'd4
  } sched_state_e;

  // One queued pose: 63 bits, last flag on top, loc1 in the low 12 bits.
  typedef struct packed {
    logic              last;
    dwell_code_e       dwell;
    logic [POSE_W-1:0] pose;
  } cmd_entry_t;

  function automatic logic [SERVO_W-1:0] pose_loc(input logic [POSE_W-1:0] pose,
                                                  input int idx);
    return pose[idx*SERVO_W +: SERVO_W];
  endfunction

endpackage

// File: rtl/servo_cmd_scheduler_if.sv
// Command, sender and status signals of the servo command scheduler.
interface servo_cmd_scheduler_if
  import robotarm_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [POSE_W-1:0]       cmd_pose;
  logic [1:0]              cmd_dwell;
  logic                    cmd_last;
  logic                    flush;
  logic [SERVO_W-1:0]      location1;
  logic [SERVO_W-1:0]      location2;
  logic [SERVO_W-1:0]      location3;
  logic [SERVO_W-1:0]      location4;
  logic [SERVO_W-1:0]      location5;
  logic                    uart_en;
  logic                    send_finish;
  logic                    busy;
  logic                    seq_done;
  logic                    err_timeout;
  logic [LVL_W-1:0]        level;

  modport slave (
    input  cmd_valid, cmd_pose, cmd_dwell, cmd_last, flush, send_finish,
    output cmd_ready, location1, location2, location3, location4, location5,
    output uart_en, busy, seq_done, err_timeout, level
  );

  modport master (
    output cmd_valid, cmd_pose, cmd_dwell, cmd_last, flush, send_finish,
    input  cmd_ready, location1, location2, location3, location4, location5,
    input  uart_en, busy, seq_done, err_timeout, level
  );

endinterface

// File: rtl/servo_cmd_scheduler_fifo.sv
// Pose FIFO with a registered head word that is valid whenever level is non-zero.
module cmd_fifo
  import robotarm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  cmd_entry_t       din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output cmd_entry_t       head_o,
  output logic [LVL_W-1:0] level_o
);

  cmd_entry_t       mem_q [DEPTH];
  cmd_entry_t       head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok    = push_i && !flush_i && (count_q != LVL_W'(DEPTH));
  assign pop_ok     = pop_i && !flush_i && (count_q != '0);
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + LVL_W'(1);
        2'b01:   count_d = count_q - LVL_W'(1);
        default: count_d = count_q;
      endcase
      // Head follows the next stored word, or takes the incoming word when the
      // queue would otherwise be empty.
      if (pop_ok) begin
        if (count_q > LVL_W'(1)) head_d = mem_q[rd_ptr_inc];
        else if (push_ok)        head_d = din_i;
      end else if (push_ok && count_q == '0) begin
        head_d = din_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign level_o = count_q;

endmodule

// File: rtl/servo_cmd_scheduler.sv
// Plays queued arm poses to the servo UART sender one at a time, pacing each
// with a send handshake, a send timeout and a per-pose settle time.
module servo_cmd_scheduler
  import robotarm_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int unsigned DWELL0       = 0,
  parameter int unsigned DWELL1       = 65_000_000,
  parameter int unsigned DWELL2       = 160_000_000,
  parameter int unsigned DWELL3       = 250_000_000,
  parameter int unsigned SEND_TIMEOUT = 1_000_000
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  servo_cmd_scheduler_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(SEND_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SEND_TIMEOUT - 1);

  sched_state_e      state_q, state_d;
  logic [POSE_W-1:0] pose_q, pose_d;
  dwell_code_e       code_q, code_d;
  logic              last_q, last_d;
  logic              uart_en_q, uart_en_d;
  logic              seq_done_q, seq_done_d;
  logic              err_q, err_d;
  logic [31:0]       dcnt_q, dcnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;

  logic              push, pop, dwell_done;
  cmd_entry_t        push_entry, head;
  logic [LVL_W-1:0]  level;
  logic [31:0]       dwell_cycles;

  assign bus.cmd_ready = (level < LVL_W'(DEPTH)) && !bus.flush;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign push_entry    = '{last: bus.cmd_last, dwell: dwell_code_e'(bus.cmd_dwell),
                           pose: bus.cmd_pose};

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .head_o  (head),
    .level_o (level)
  );

  always_comb begin
    case (code_q)
      DWELL_C0: dwell_cycles = 32'(DWELL0);
      DWELL_C1: dwell_cycles = 32'(DWELL1);
      DWELL_C2: dwell_cycles = 32'(DWELL2);
      default:  dwell_cycles = 32'(DWELL3);
    endcase
  end

  assign dwell_done = (dwell_cycles == 32'd0) || (dcnt_q == dwell_cycles - 32'd1);

  always_comb begin
    state_d    = state_q;
    pose_d     = pose_q;
    code_d     = code_q;
    last_d     = last_q;
    uart_en_d  = 1'b0;
    seq_done_d = 1'b0;
    err_d      = err_q;
    dcnt_d     = dcnt_q;
    tcnt_d     = tcnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: if (level != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        // A flush on the IDLE->LOAD edge can leave nothing to load.
        if (level != '0) begin
          pop       = 1'b1;
          pose_d    = head.pose;
          code_d    = head.dwell;
          last_d    = head.last;
          uart_en_d = 1'b1;
          tcnt_d    = '0;
          state_d   = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        tcnt_d  = tcnt_q + TO_W'(1);
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // The send wait is counted from the uart_en cycle.
        if (bus.send_finish) begin
          dcnt_d  = '0;
          state_d = ST_DWELL;
        end else if (tcnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          dcnt_d  = '0;
          state_d = ST_DWELL;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      ST_DWELL: begin
        if (dwell_done) begin
          seq_done_d = last_q;
          state_d    = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) err_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      pose_q     <= HOME_POSE;
      code_q     <= DWELL_C0;
      last_q     <= 1'b0;
      uart_en_q  <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      dcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pose_q     <= pose_d;
      code_q     <= code_d;
      last_q     <= last_d;
      uart_en_q  <= uart_en_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
      dcnt_q     <= dcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.location1   = pose_loc(pose_q, 0);
  assign bus.location2   = pose_loc(pose_q, 1);
  assign bus.location3   = pose_loc(pose_q, 2);
  assign bus.location4   = pose_loc(pose_q, 3);
  assign bus.location5   = pose_loc(pose_q, 4);
  assign bus.uart_en     = uart_en_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.err_timeout = err_q;
  assign bus.busy        = (state_q != ST_IDLE) || (level != '0);
  assign bus.level       = level;

endmodule
